// File: rtl/sram_responder.sv
// SRAM-bus memory responder: byte-lane writes, latency-configurable reads with registered drive enable.
// Read data appears READ_LATENCY edges after the capture edge; an abort, write or address change drops Data_Oe at the sampling edge.
module sram_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int READ_LATENCY = 2   // legal range 1..15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_In,
    output logic [15:0] Data_Out,
    output logic        Data_Oe,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int         DEPTH      = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_RELOAD = 4'(READ_LATENCY - 1);

    logic [15:0] mem [DEPTH];

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [19:0] cap_addr, cap_addr_nxt;
    logic        cap_ub, cap_ub_nxt;
    logic        cap_lb, cap_lb_nxt;
    logic [15:0] dout_nxt;
    logic        oe_nxt;
    logic        capture;

    logic                 wr_en;
    logic                 rd_req;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [15:0]          rd_word;
    logic [15:0]          rd_masked;

    assign wr_en   = !CE && !WE;
    assign rd_req  = !CE && WE && !OE;
    assign wr_addr = ADDR[ADDR_BITS-1:0];

    // Memory is read at DRIVE entry, so a write landing before that edge is always visible.
    assign rd_word   = mem[cap_addr[ADDR_BITS-1:0]];
    assign rd_masked = {cap_ub ? 8'h00 : rd_word[15:8],
                        cap_lb ? 8'h00 : rd_word[7:0]};

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            if (!UB) mem[wr_addr][15:8] <= Data_In[15:8];
            if (!LB) mem[wr_addr][7:0]  <= Data_In[7:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            cap_addr <= 20'd0;
            cap_ub   <= 1'b0;
            cap_lb   <= 1'b0;
            Data_Out <= 16'h0000;
            Data_Oe  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cap_addr <= cap_addr_nxt;
            cap_ub   <= cap_ub_nxt;
            cap_lb   <= cap_lb_nxt;
            Data_Out <= dout_nxt;
            Data_Oe  <= oe_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cap_addr_nxt = cap_addr;
        cap_ub_nxt   = cap_ub;
        cap_lb_nxt   = cap_lb;
        dout_nxt     = Data_Out;
        oe_nxt       = Data_Oe;
        capture      = 1'b0;

        case (state)
            IDLE: begin
                oe_nxt = 1'b0;
                if (rd_req) begin
                    capture   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Anything other than a continuing read (idle, OE high, or a write) abandons it.
                if (!rd_req) begin
                    state_nxt = IDLE;
                    oe_nxt    = 1'b0;
                end else if (cnt == 4'd0) begin
                    state_nxt = DRIVE;
                    dout_nxt  = rd_masked;
                    oe_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DRIVE: begin
                if (!rd_req) begin
                    state_nxt = IDLE;
                    oe_nxt    = 1'b0;
                end else if (ADDR != cap_addr) begin
                    capture   = 1'b1;
                    state_nxt = WAIT;
                    oe_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                oe_nxt    = 1'b0;
            end
        endcase

        if (capture) begin
            cap_addr_nxt = ADDR;
            cap_ub_nxt   = UB;
            cap_lb_nxt   = LB;
            cnt_nxt      = LAT_RELOAD;
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: reference memory model plus a queue of expected read words.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        CE = 1'b1, UB = 1'b0, LB = 1'b0, OE = 1'b1, WE = 1'b1;
    logic [19:0] ADDR = 20'd0;
    logic [15:0] Data_In = 16'd0;
    logic [15:0] Data_Out;
    logic        Data_Oe;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] model [256];
    logic [15:0] exp_q [$];

    sram_responder #(.ADDR_BITS(8), .READ_LATENCY(2)) dut (
        .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data_In(Data_In), .Data_Out(Data_Out), .Data_Oe(Data_Oe), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        @(negedge Clk);
        CE = 1'b1; WE = 1'b1; OE = 1'b1; UB = 1'b0; LB = 1'b0;
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
        @(negedge Clk);
        CE = 1'b0; WE = 1'b0; OE = 1'b1; ADDR = a; Data_In = d; UB = ub; LB = lb;
        @(posedge Clk); #1;
        chk("oe_low_on_write", Data_Oe, 0);
        if (!ub) model[a[7:0]][15:8] = d[15:8];
        if (!lb) model[a[7:0]][7:0]  = d[7:0];
        go_idle();
    endtask

    function automatic logic [15:0] expect_rd(input logic [19:0] a, input logic ub, input logic lb);
        logic [15:0] w;
        w = model[a[7:0]];
        return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
    endfunction

    // Counts edges after a capture until Data_Oe rises, then scores the popped expectation.
    task automatic wait_drive(input string tag);
        int n;
        logic [15:0] e;
        n = 0;
        while (!Data_Oe && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk({tag, "_data"}, Data_Out, e);
    endtask

    task automatic do_read(input string tag, input logic [19:0] a, input logic ub, input logic lb);
        @(negedge Clk);
        CE = 1'b0; WE = 1'b1; OE = 1'b0; ADDR = a; UB = ub; LB = lb;
        exp_q.push_back(expect_rd(a, ub, lb));
        @(posedge Clk); #1;
        chk({tag, "_busy"}, Busy, 1);
        wait_drive(tag);
    endtask

    task automatic end_read(input string tag);
        go_idle();
        @(posedge Clk); #1;
        chk({tag, "_end_oe"}, Data_Oe, 0);
        chk({tag, "_end_busy"}, Busy, 0);
    endtask

    initial begin
        #1;
        chk("rst_oe", Data_Oe, 0);
        chk("rst_out", Data_Out, 16'h0000);
        chk("rst_busy", Busy, 0);
        @(negedge Clk);
        Reset = 1'b0;

        do_write(20'h00012, 16'hBEEF, 1'b0, 1'b0);
        do_read("rd_beef", 20'h00012, 1'b0, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        chk("hold_oe", Data_Oe, 1);
        chk("hold_data", Data_Out, 16'hBEEF);
        end_read("rd_beef");

        do_write(20'h00012, 16'h1234, 1'b1, 1'b0);
        do_read("rd_lane", 20'h00012, 1'b0, 1'b1);
        chk("lane_const", Data_Out, 16'hBE00);
        end_read("rd_lane");

        do_write(20'h00103, 16'hA5A5, 1'b0, 1'b0);
        do_read("rd_alias", 20'h00003, 1'b0, 1'b0);
        end_read("rd_alias");

        // OE abort one edge after capture
        @(negedge Clk);
        CE = 1'b0; WE = 1'b1; OE = 1'b0; ADDR = 20'h00012;
        @(negedge Clk);
        OE = 1'b1;
        @(posedge Clk); #1;
        chk("abort_busy", Busy, 0);
        chk("abort_oe", Data_Oe, 0);
        repeat (3) @(posedge Clk);
        #1;
        chk("abort_oe_later", Data_Oe, 0);
        go_idle();

        // Write during WAIT abandons the read but lands
        @(negedge Clk);
        CE = 1'b0; WE = 1'b1; OE = 1'b0; ADDR = 20'h00012;
        @(negedge Clk);
        WE = 1'b0; ADDR = 20'h00020; Data_In = 16'h7777;
        model[8'h20] = 16'h7777;
        @(posedge Clk); #1;
        chk("wabort_busy", Busy, 0);
        chk("wabort_oe", Data_Oe, 0);
        go_idle();
        do_read("rd_wabort", 20'h00020, 1'b0, 1'b0);
        end_read("rd_wabort");

        // Address change while driving restarts with full latency
        do_write(20'h00013, 16'h5A5A, 1'b0, 1'b0);
        do_read("rd_pre", 20'h00012, 1'b0, 1'b0);
        @(negedge Clk);
        ADDR = 20'h00013;
        exp_q.push_back(expect_rd(20'h00013, 1'b0, 1'b0));
        @(posedge Clk); #1;
        chk("achg_oe_drop", Data_Oe, 0);
        chk("achg_busy", Busy, 1);
        wait_drive("rd_achg");

        // Asynchronous reset in the middle of DRIVE
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_oe", Data_Oe, 0);
        chk("arst_out", Data_Out, 16'h0000);
        chk("arst_busy", Busy, 0);
        @(negedge Clk);
        CE = 1'b1; WE = 1'b1; OE = 1'b1;
        Reset = 1'b0;
        do_read("rd_post_rst", 20'h00012, 1'b0, 1'b0);
        chk("post_rst_val", Data_Out, 16'hBE34);
        end_read("rd_post_rst");

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
